// File: rtl/lsu_dccm_wbuf_mem.sv
// Banked DCCM with an in-order store buffer; reads own the banks, stores drain into idle banks.
// Define DCCM_WBUF_FWD_EN to forward queued store data to loads instead of stalling matching reads.
module lsu_dccm_wbuf_mem #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_WIDTH_BITS  = 2,
  parameter int DCCM_BANK_BITS   = 2,
  parameter int DCCM_NUM_BANKS   = 4,
  parameter int DCCM_FDATA_WIDTH = 39,
  parameter int WBUF_DEPTH       = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rd_valid,
  output logic                              rd_ready,
  input  logic [DCCM_BITS-1:0]              rd_addr_lo,
  input  logic [DCCM_BITS-1:0]              rd_addr_hi,
  output logic                              rd_data_valid,
  output logic [DCCM_FDATA_WIDTH-1:0]       rd_data_lo,
  output logic [DCCM_FDATA_WIDTH-1:0]       rd_data_hi,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [DCCM_BITS-1:0]              wr_addr_lo,
  input  logic [DCCM_BITS-1:0]              wr_addr_hi,
  input  logic [DCCM_FDATA_WIDTH-1:0]       wr_data_lo,
  input  logic [DCCM_FDATA_WIDTH-1:0]       wr_data_hi,
  output logic [$clog2(WBUF_DEPTH):0]       wbuf_count,
  output logic                              wbuf_empty
);
  localparam int INDEX_BITS = DCCM_BITS - DCCM_BANK_BITS - DCCM_WIDTH_BITS;
  localparam int BANK_DEPTH = 2**INDEX_BITS;
  localparam int PTR_W      = $clog2(WBUF_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  typedef struct packed {
    logic [DCCM_BANK_BITS-1:0]   bank;
    logic [INDEX_BITS-1:0]       index;
    logic [DCCM_FDATA_WIDTH-1:0] data;
  } entry_t;

  function automatic logic [DCCM_BANK_BITS-1:0] bank_of(input logic [DCCM_BITS-1:0] addr);
    return addr[DCCM_WIDTH_BITS +: DCCM_BANK_BITS];
  endfunction

  function automatic logic [INDEX_BITS-1:0] index_of(input logic [DCCM_BITS-1:0] addr);
    return addr[DCCM_WIDTH_BITS+DCCM_BANK_BITS +: INDEX_BITS];
  endfunction

  logic [DCCM_FDATA_WIDTH-1:0] mem [DCCM_NUM_BANKS][BANK_DEPTH];
  entry_t                      wbuf [WBUF_DEPTH];
  logic [PTR_W-1:0]            head_ptr, tail_ptr;
  logic [CNT_W-1:0]            count;
  logic [WBUF_DEPTH-1:0]       ent_vld, lo_match, hi_match;

  logic [DCCM_BANK_BITS-1:0]   rd_bank_lo, rd_bank_hi;
  logic [INDEX_BITS-1:0]       rd_idx_lo, rd_idx_hi;
  logic                        rd_unal, wr_unal, rd_fire, wr_fire, pop;
  logic [1:0]                  push_n;
  entry_t                      head;
  logic                        unused_addr_bits;

  assign unused_addr_bits = ^{rd_addr_lo[DCCM_WIDTH_BITS-1:0], rd_addr_hi[DCCM_WIDTH_BITS-1:0],
                              wr_addr_lo[DCCM_WIDTH_BITS-1:0], wr_addr_hi[DCCM_WIDTH_BITS-1:0]};

  assign rd_bank_lo = bank_of(rd_addr_lo);
  assign rd_bank_hi = bank_of(rd_addr_hi);
  assign rd_idx_lo  = index_of(rd_addr_lo);
  assign rd_idx_hi  = index_of(rd_addr_hi);
  assign rd_unal    = (rd_bank_lo != rd_bank_hi);
  assign wr_unal    = (bank_of(wr_addr_lo) != bank_of(wr_addr_hi));

  assign wr_ready   = (count <= CNT_W'(WBUF_DEPTH-2));
  assign wbuf_count = count;
  assign wbuf_empty = (count == '0);
  assign rd_fire    = rd_valid & rd_ready;
  assign wr_fire    = wr_valid & wr_ready;
  assign push_n     = wr_fire ? (wr_unal ? 2'd2 : 2'd1) : 2'd0;
  assign head       = wbuf[head_ptr];
  // For an aligned read both bank fields are equal, so comparing both is always correct.
  assign pop        = (count != '0) &&
                      !(rd_fire && ((head.bank == rd_bank_lo) || (head.bank == rd_bank_hi)));

  always_comb begin
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      ent_vld[i]  = ({1'b0, PTR_W'(i) - head_ptr} < count);
      lo_match[i] = ent_vld[i] && (wbuf[i].bank == rd_bank_lo) && (wbuf[i].index == rd_idx_lo);
      hi_match[i] = ent_vld[i] && rd_unal && (wbuf[i].bank == rd_bank_hi) && (wbuf[i].index == rd_idx_hi);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      head_ptr <= head_ptr + PTR_W'(pop);
      tail_ptr <= tail_ptr + PTR_W'(push_n);
      count    <= count + CNT_W'(push_n) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      wbuf[tail_ptr] <= '{bank: bank_of(wr_addr_lo), index: index_of(wr_addr_lo), data: wr_data_lo};
      if (wr_unal)
        wbuf[tail_ptr + PTR_W'(1)] <= '{bank: bank_of(wr_addr_hi), index: index_of(wr_addr_hi),
                                        data: wr_data_hi};
    end
  end

  // ---- stage p0 -> p1: bank array access and read result capture ----
  logic [DCCM_FDATA_WIDTH-1:0] arr_lo_p1, arr_hi_p1, word_lo, word_hi;
  logic                        vld_p1, unal_p1;

  always_ff @(posedge clk) begin
    if (pop)
      mem[head.bank][head.index] <= head.data;
    if (rd_fire) begin
      arr_lo_p1 <= mem[rd_bank_lo][rd_idx_lo];
      arr_hi_p1 <= mem[rd_bank_hi][rd_idx_hi];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      unal_p1 <= 1'b0;
    end else begin
      vld_p1  <= rd_fire;
      if (rd_fire)
        unal_p1 <= rd_unal;
    end
  end

`ifdef DCCM_WBUF_FWD_EN
  logic                        fwd_lo_hit, fwd_hi_hit, fwd_lo_hit_p1, fwd_hi_hit_p1;
  logic [DCCM_FDATA_WIDTH-1:0] fwd_lo_data, fwd_hi_data, fwd_lo_p1, fwd_hi_p1;
  logic [PTR_W-1:0]            slot;

  // Walk oldest to youngest so the last hit is the youngest store.
  always_comb begin
    fwd_lo_hit  = 1'b0;
    fwd_hi_hit  = 1'b0;
    fwd_lo_data = '0;
    fwd_hi_data = '0;
    slot        = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      slot = head_ptr + PTR_W'(k);
      if (lo_match[slot]) begin
        fwd_lo_hit  = 1'b1;
        fwd_lo_data = wbuf[slot].data;
      end
      if (hi_match[slot]) begin
        fwd_hi_hit  = 1'b1;
        fwd_hi_data = wbuf[slot].data;
      end
    end
  end

  assign rd_ready = 1'b1;

  always_ff @(posedge clk) begin
    if (rd_fire) begin
      fwd_lo_p1 <= fwd_lo_data;
      fwd_hi_p1 <= fwd_hi_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_lo_hit_p1 <= 1'b0;
      fwd_hi_hit_p1 <= 1'b0;
    end else if (rd_fire) begin
      fwd_lo_hit_p1 <= fwd_lo_hit;
      fwd_hi_hit_p1 <= fwd_hi_hit;
    end
  end

  assign word_lo = fwd_lo_hit_p1 ? fwd_lo_p1 : arr_lo_p1;
  assign word_hi = fwd_hi_hit_p1 ? fwd_hi_p1 : arr_hi_p1;
`else
  // Hold off a read that would miss pending store data; it claims no bank, so the drain continues.
  assign rd_ready = !(rd_valid && ((|lo_match) || (|hi_match)));
  assign word_lo  = arr_lo_p1;
  assign word_hi  = arr_hi_p1;
`endif

  assign rd_data_valid = vld_p1;
  assign rd_data_lo    = vld_p1 ? word_lo : '0;
  assign rd_data_hi    = !vld_p1 ? '0 : (unal_p1 ? word_hi : word_lo);

endmodule

// File: tb/tb_lsu_dccm_wbuf_mem.sv
// Directed bench for lsu_dccm_wbuf_mem; expectations adapt to whether DCCM_WBUF_FWD_EN is defined.
module tb_lsu_dccm_wbuf_mem;
  localparam int FW = 39;
`ifdef DCCM_WBUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [FW-1:0] DA = 39'h12_3456_789A;
  localparam logic [FW-1:0] DB = 39'h7F_0000_BEEF;

  logic          clk, rst;
  logic          rd_valid, rd_ready, rd_data_valid;
  logic [15:0]   rd_addr_lo, rd_addr_hi;
  logic [FW-1:0] rd_data_lo, rd_data_hi;
  logic          wr_valid, wr_ready;
  logic [15:0]   wr_addr_lo, wr_addr_hi;
  logic [FW-1:0] wr_data_lo, wr_data_hi;
  logic [2:0]    wbuf_count;
  logic          wbuf_empty;
  int            checks = 0;
  int            errors = 0;

  lsu_dccm_wbuf_mem dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr_lo(rd_addr_lo), .rd_addr_hi(rd_addr_hi),
    .rd_data_valid(rd_data_valid), .rd_data_lo(rd_data_lo), .rd_data_hi(rd_data_hi),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr_lo(wr_addr_lo), .wr_addr_hi(wr_addr_hi),
    .wr_data_lo(wr_data_lo), .wr_data_hi(wr_data_hi),
    .wbuf_count(wbuf_count), .wbuf_empty(wbuf_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [15:0] lo, input logic [15:0] hi,
                        input logic [FW-1:0] dlo, input logic [FW-1:0] dhi);
    wr_valid = 1'b1; wr_addr_lo = lo; wr_addr_hi = hi; wr_data_lo = dlo; wr_data_hi = dhi;
  endtask

  task automatic set_rd(input logic [15:0] lo, input logic [15:0] hi);
    rd_valid = 1'b1; rd_addr_lo = lo; rd_addr_hi = hi;
  endtask

  task automatic rd_word(input logic [15:0] lo, input logic [15:0] hi, input int exp_wait,
                         input logic [FW-1:0] exp_lo, input logic [FW-1:0] exp_hi, input string tag);
    int waited;
    waited = 0;
    set_rd(lo, hi);
    #1;
    while (!rd_ready && waited < 20) begin
      step();
      waited++;
    end
    chk({tag, "_stall"}, waited, exp_wait);
    step();
    rd_valid = 1'b0;
    chk({tag, "_vld"}, rd_data_valid, 1);
    chk({tag, "_lo"}, rd_data_lo, exp_lo);
    chk({tag, "_hi"}, rd_data_hi, exp_hi);
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (!wbuf_empty && n < 20) begin
      step();
      n++;
    end
    chk(tag, wbuf_empty, 1);
  endtask

  initial begin
    rst = 1'b1; rd_valid = 1'b0; wr_valid = 1'b0;
    rd_addr_lo = '0; rd_addr_hi = '0; wr_addr_lo = '0; wr_addr_hi = '0;
    wr_data_lo = '0; wr_data_hi = '0;
    step(); step();
    chk("rst_count", wbuf_count, 0);
    chk("rst_empty", wbuf_empty, 1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_ready", rd_ready, 1);
    chk("rst_rd_vld", rd_data_valid, 0);
    chk("rst_rd_lo", rd_data_lo, 0);
    rst = 1'b0;
    step();

    // single aligned store, drain, then load from the array
    set_wr(16'h0010, 16'h0010, 39'h7F, 39'h7F);
    step();
    wr_valid = 1'b0;
    chk("t1_count1", wbuf_count, 1);
    chk("t1_not_empty", wbuf_empty, 0);
    step();
    chk("t1_empty", wbuf_empty, 1);
    step();
    rd_word(16'h0010, 16'h0010, 0, 39'h7F, 39'h7F, "t1_rd");
    step();
    chk("t1_vld_pulse", rd_data_valid, 0);

    // unaligned store takes two slots
    set_wr(16'h000C, 16'h0010, DA, DB);
    step();
    wr_valid = 1'b0;
    chk("t2_count2", wbuf_count, 2);
    rd_word(16'h000C, 16'h0010, FWD ? 0 : 2, DA, DB, "t2_rd");
    wait_empty("t2_drain");

    // two stores to one word held back by bank-0 reads, then load sees the younger one
    set_rd(16'h0000, 16'h0000);
    set_wr(16'h0020, 16'h0020, 39'h11, 39'h11);
    step();
    set_wr(16'h0020, 16'h0020, 39'h22, 39'h22);
    step();
    wr_valid = 1'b0;
    chk("t3_count2", wbuf_count, 2);
    rd_word(16'h0020, 16'h0020, FWD ? 0 : 2, 39'h22, 39'h22, "t3_rd");
    wait_empty("t3_drain");

    // fill while the head bank is continuously read
    set_rd(16'h0000, 16'h0000);
    set_wr(16'h0040, 16'h0040, 39'h40, 39'h40);
    step();
    chk("t4_count1", wbuf_count, 1);
    set_wr(16'h0050, 16'h0050, 39'h50, 39'h50);
    step();
    chk("t4_count2", wbuf_count, 2);
    chk("t4_ready_at2", wr_ready, 1);
    set_wr(16'h0060, 16'h0060, 39'h60, 39'h60);
    step();
    chk("t4_count3", wbuf_count, 3);
    chk("t4_ready_at3", wr_ready, 0);
    chk("t4_rd_ready", rd_ready, 1);
    set_wr(16'h0070, 16'h0070, 39'h70, 39'h70);
    step();
    chk("t4_starved", wbuf_count, 3);
    rd_valid = 1'b0; wr_valid = 1'b0;
    step();
    chk("t4_drain2", wbuf_count, 2);
    chk("t4_ready_again", wr_ready, 1);
    step();
    chk("t4_drain1", wbuf_count, 1);
    step();
    chk("t4_drain0", wbuf_count, 0);
    rd_word(16'h0060, 16'h0060, 0, 39'h60, 39'h60, "t4_rd");

    // same-cycle read and write: the read sees the old value
    set_wr(16'h0030, 16'h0030, 39'h05, 39'h05);
    step();
    wr_valid = 1'b0;
    wait_empty("t5_init");
    set_rd(16'h0030, 16'h0030);
    set_wr(16'h0030, 16'h0030, 39'h09, 39'h09);
    #1;
    chk("t5_rd_ready", rd_ready, 1);
    step();
    rd_valid = 1'b0; wr_valid = 1'b0;
    chk("t5_old_vld", rd_data_valid, 1);
    chk("t5_old", rd_data_lo, 39'h05);
    rd_word(16'h0030, 16'h0030, FWD ? 0 : 1, 39'h09, 39'h09, "t5_new");
    wait_empty("t5_drain");

    // reset with three queued stores discards them
    set_wr(16'h0080, 16'h0080, 39'h55, 39'h55);
    step();
    wr_valid = 1'b0;
    wait_empty("t6_init");
    set_rd(16'h0000, 16'h0000);
    set_wr(16'h0080, 16'h0080, 39'h66, 39'h66);
    step();
    set_wr(16'h0090, 16'h0090, 39'h77, 39'h77);
    step();
    set_wr(16'h00A0, 16'h00A0, 39'h88, 39'h88);
    step();
    wr_valid = 1'b0;
    chk("t6_count3", wbuf_count, 3);
    chk("t6_vld_before", rd_data_valid, 1);
    rst = 1'b1; rd_valid = 1'b0;
    #1;
    chk("t6_count0", wbuf_count, 0);
    chk("t6_empty", wbuf_empty, 1);
    chk("t6_rd_vld", rd_data_valid, 0);
    chk("t6_rd_lo", rd_data_lo, 0);
    chk("t6_wr_ready", wr_ready, 1);
    step();
    rst = 1'b0;
    step(); step(); step();
    chk("t6_still_empty", wbuf_count, 0);
    rd_word(16'h0080, 16'h0080, 0, 39'h55, 39'h55, "t6_arr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
